regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (WE3/A3/WD3) between two writers:
- The in-order pipeline writeback stage (WB), which has no handshake.
- A long-latency unit (LLU, e.g. divider or load miss), which uses a valid/ready handshake.
LLU results are buffered in a small FIFO and drained into free write-port cycles. The block also answers decode's hazard queries against pending buffered writes, and has an optional starvation guard that briefly freezes the pipeline so the buffer can drain.

Parameters:
XLEN, 32, data width
REG_ADDR_W, 5, register address width
FIFO_DEPTH, 4, LLU result buffer entries; power of two, ≥2
MAX_WAIT, 8, cycles the FIFO head may be denied before a forced drain; ≥1

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
wb_we  in  1  pipeline WB write request
wb_rd  in  REG_ADDR_W  pipeline WB destination
wb_data  in  XLEN  pipeline WB data
llu_valid  in  1  LLU result valid
llu_rd  in  REG_ADDR_W  LLU destination
llu_data  in  XLEN  LLU data
llu_ready  out  1  FIFO can accept
q_a1, q_a2  in  REG_ADDR_W  decode source registers to check
q_hit1, q_hit2  out  1  source matches a pending FIFO entry; decode must stall
pipe_stall  out  1  WB input ignored this cycle; pipeline must freeze and re-present it
rf_we  out  1  to register file WE3
rf_a  out  REG_ADDR_W  to A3
rf_wd  out  XLEN  to WD3
fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
Reset:
- Synchronous reset; clk and rst naming and polarity are already decided.
- While rst=1: FIFO empty, fifo_count=0, state=IDLE, wait_cnt=0.
- While rst=1, all outputs are forced to 0, including llu_ready.

Output timing:
- Write-port outputs are combinational from current inputs and registered state. The register file samples them on the following negedge, so there is zero added cycle latency for WB.

Push path:
- llu_ready = !full. The FIFO does not accept when full, even if a pop occurs in the same cycle.
- Push occurs when llu_valid && llu_ready.
- An entry with llu_rd=0 is accepted but not stored (x0 discard).

Grant in state IDLE:
- If wb_we && wb_rd!=0: grant WB. rf_we=1, rf_a=wb_rd, rf_wd=wb_data.
- Else, if the FIFO is non-empty: pop the head. rf_we=1, rf_a/rf_wd come from the head.
- Else rf_we=0. rf_a and rf_wd are then don't-care; drive 0.
- WB with rd=0 never asserts rf_we.

Grant in state DRAIN:
- pipe_stall=1; WB inputs are ignored.
- Pop the head unconditionally; the FIFO is guaranteed non-empty in DRAIN.
- Next state is IDLE and wait_cnt is cleared to 0.

wait_cnt:
- Cleared on any pop or whenever the FIFO is empty.
- Otherwise increments when the FIFO is non-empty and the head is denied.
- IDLE→DRAIN on the posedge where the head is denied and wait_cnt==MAX_WAIT-1.

Simultaneous push and pop:
- Both occur in the same cycle; count is unchanged.
- A push into an empty FIFO cannot be popped in the same cycle. The earliest write of a new entry is the next cycle.

Hazard query:
- q_hitN=1 if any valid FIFO entry has rd==q_aN and q_aN!=0.
- This is combinational over all entries and includes the entry being popped this cycle. That is conservative but safe: the regfile is written at negedge and read at the next negedge.

Write ordering:
- If WB and a pending entry target the same rd, the FIFO entry writes later and is the final value. Issue logic must use q_hit to prevent such WAW cases.

Optional Feature:
REGFILE_ARB_STARVE_GUARD_EN:
- Defined: the DRAIN state and wait_cnt exist as described above.
- Undefined: no DRAIN state, no wait counter, and pipe_stall is tied to 0. WB has strict priority, and the FIFO drains only in WB-idle cycles. A full FIFO back-pressures the LLU indefinitely.

Decomposition:
Shared package (riscv_pkg):
- XLEN and REG_ADDR_W constants.
- Arbiter state enum {IDLE, DRAIN}.
- wb_req struct {we, rd, data}.
One sub-module is natural:
- wb_fifo: a parameterised sync FIFO over {rd, data} with count and a parallel rd-compare hazard output.
- The top level holds the grant mux, the FSM and wait_cnt.

Test Plan:
1. Reset/idle: rst 2 cycles → all outputs 0. After release with no requests → rf_we=0, llu_ready=1, fifo_count=0.
2. WB-only: wb_we=1, rd=5, data=0xDEADBEEF → same cycle rf_we=1, rf_a=5, rf_wd=0xDEADBEEF. Then rd=0 → rf_we=0.
3. LLU in gap: push rd=7, data=0x1234 with WB idle → next cycle rf_we=1, rf_a=7. q_a1=7 gives q_hit1=1 until that pop.
4. Full/back-pressure: WB busy continuously (guard off) and 5 LLU pushes → 4 accepted, llu_ready=0, 5th held. Release WB → four pops in FIFO order.
5. Starvation (guard on, MAX_WAIT=8): WB busy every cycle and 1 LLU entry → pipe_stall=1 in exactly the 9th cycle after the push, head written, WB ignored that cycle.
6. Mid-operation reset: 3 entries queued and rst pulsed in DRAIN → FIFO flushed, q_hit=0, state IDLE, no rf_we while rst=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Widths, arbiter states and the write-request bundle.
package regfile_wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE,
    DRAIN
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Sync FIFO of {rd, data} LLU results with occupancy count
// and a parallel rd compare over every live entry for hazards.
module regfile_wb_arbiter_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wr_rd,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] q_a1,
  input  logic [AW-1:0] q_a2,
  output logic [AW-1:0] head_rd,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          hit1,
  output logic          hit2
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0]    rd_q   [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] live;

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset; liveness comes from the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr_q]   <= wr_rd;
      data_q[wptr_q] <= wr_data;
    end
  end

  // An entry is live when its distance from the head is below count
  always_comb begin
    live = '0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = {1'b0, PW'(i) - rptr_q} < count_q;
      if (live[i] && q_a1 != '0 && rd_q[i] == q_a1) hit1 = 1'b1;
      if (live[i] && q_a2 != '0 && rd_q[i] == q_a2) hit2 = 1'b1;
    end
  end

  assign head_rd   = rd_q[rptr_q];
  assign head_data = data_q[rptr_q];
  assign count     = count_q;
  assign full      = count_q == CW'(DEPTH);
  assign empty     = count_q == '0;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between WB and buffered LLU results.
// REGFILE_ARB_STARVE_GUARD_EN adds a forced-drain state with pipe stall.
module regfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wb_we,
  input  logic [REG_ADDR_W-1:0]          wb_rd,
  input  logic [XLEN-1:0]                wb_data,
  input  logic                           llu_valid,
  input  logic [REG_ADDR_W-1:0]          llu_rd,
  input  logic [XLEN-1:0]                llu_data,
  output logic                           llu_ready,
  input  logic [REG_ADDR_W-1:0]          q_a1,
  input  logic [REG_ADDR_W-1:0]          q_a2,
  output logic                           q_hit1,
  output logic                           q_hit2,
  output logic                           pipe_stall,
  output logic                           rf_we,
  output logic [REG_ADDR_W-1:0]          rf_a,
  output logic [XLEN-1:0]                rf_wd,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  import regfile_wb_arbiter_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2
      || MAX_WAIT < 1) begin : g_bad_cfg
    $error("regfile_wb_arbiter: bad FIFO_DEPTH or MAX_WAIT");
  end

  logic                  push, store, pop, take_wb;
  logic                  full, empty, hit1, hit2;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic [CW-1:0]         count;
  wb_req_t               grant;

  assign llu_ready = !rst && !full;
  assign push      = llu_valid && llu_ready;
  assign store     = push && llu_rd != '0;

  regfile_wb_arbiter_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (REG_ADDR_W),
    .DW    (XLEN),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (store),
    .pop       (pop),
    .wr_rd     (llu_rd),
    .wr_data   (llu_data),
    .q_a1      (q_a1),
    .q_a2      (q_a2),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .hit1      (hit1),
    .hit2      (hit2)
  );

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);

  arb_state_e    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;

  // State and head-starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // DRAIN pops unconditionally; IDLE gives WB priority and counts denials
  always_comb begin
    state_d = IDLE;
    wait_d  = wait_q;
    take_wb = 1'b0;
    pop     = 1'b0;
    if (state_q == DRAIN) begin
      pop    = !empty;
      wait_d = '0;
    end else begin
      take_wb = wb_we && wb_rd != '0;
      pop     = !take_wb && !empty;
      if (pop || empty) begin
        wait_d = '0;
      end else begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WW'(MAX_WAIT - 1)) state_d = DRAIN;
      end
    end
  end

  assign pipe_stall = !rst && state_q == DRAIN;
`else
  assign take_wb    = wb_we && wb_rd != '0;
  assign pop        = !take_wb && !empty;
  assign pipe_stall = 1'b0;
`endif

  // Write-port mux; take_wb and pop never assert together
  always_comb begin
    grant = '0;
    if (!rst) begin
      unique case (1'b1)
        take_wb: grant = '{we: 1'b1, rd: wb_rd, data: wb_data};
        pop:     grant = '{we: 1'b1, rd: head_rd, data: head_data};
        default: grant = '0;
      endcase
    end
  end

  assign rf_we      = grant.we;
  assign rf_a       = grant.rd;
  assign rf_wd      = grant.data;
  assign q_hit1     = !rst && hit1;
  assign q_hit2     = !rst && hit2;
  assign fifo_count = rst ? '0 : count;

endmodule
